// File: rtl/corr_iq.sv
// corr_iq: single-bin I/Q correlator over N-sample windows (sine -> I, cosine -> Q).
// Define CORR_IQ_MAG_EN to add the registered |I|+|Q| magnitude output.
module corr_iq #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int N     = 20,
    parameter int OW    = 10,
    parameter int SHIFT = DW + CW + $clog2(N) - OW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        in_valid,
    input  logic signed [DW-1:0]        in_data,
    output logic                        out_valid,
    output logic signed [OW-1:0]        out_i,
    output logic signed [OW-1:0]        out_q,
    output logic                        out_sat,
    output logic        [OW:0]          out_mag,
    output logic        [$clog2(N)-1:0] idx
);

    localparam int  IW = $clog2(N);
    localparam int  PW = DW + CW;
    localparam int  AW = DW + CW + $clog2(N);
    localparam int  M  = 2**(CW-1) - 1;
    localparam real PI = 3.14159265358979323846;

    localparam logic [IW-1:0]        LAST = IW'(N - 1);
    localparam logic signed [AW-1:0] OMAX = AW'(2**(OW-1) - 1);
    localparam logic signed [AW-1:0] OMIN = AW'(-(2**(OW-1)));

    function automatic logic is_sat(input logic signed [AW-1:0] v);
        return (v > OMAX) || (v < OMIN);
    endfunction

    function automatic logic signed [OW-1:0] sat_ow(input logic signed [AW-1:0] v);
        if (v > OMAX) return {1'b0, {(OW-1){1'b1}}};
        if (v < OMIN) return {1'b1, {(OW-1){1'b0}}};
        return v[OW-1:0];
    endfunction

    // Coefficient ROMs, rounded half away from zero at elaboration.
    logic signed [CW-1:0] sin_tab [N];
    logic signed [CW-1:0] cos_tab [N];

    for (genvar k = 0; k < N; k++) begin : g_coef
        localparam real SR = M * $sin(2.0 * PI * k / N);
        localparam real CR = M * $cos(2.0 * PI * k / N);
        localparam int  SI = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
        localparam int  CI = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        assign sin_tab[k] = CW'(SI);
        assign cos_tab[k] = CW'(CI);
    end

    logic [IW-1:0]        idx_q, idx_d;
    logic signed [AW-1:0] acc_s_q, acc_s_d;
    logic signed [AW-1:0] acc_c_q, acc_c_d;
    logic signed [PW-1:0] prod_s, prod_c;
    logic                 done_d;
    logic                 vld_q;

    assign prod_s = PW'(in_data) * PW'(sin_tab[idx_q]);
    assign prod_c = PW'(in_data) * PW'(cos_tab[idx_q]);

    // Accumulate stage: idx 0 reloads so no state leaks between windows.
    always_comb begin
        idx_d   = idx_q;
        acc_s_d = acc_s_q;
        acc_c_d = acc_c_q;
        done_d  = 1'b0;
        if (clr) begin
            idx_d   = '0;
            acc_s_d = '0;
            acc_c_d = '0;
        end else if (in_valid) begin
            if (idx_q == '0) begin
                acc_s_d = AW'(prod_s);
                acc_c_d = AW'(prod_c);
            end else begin
                acc_s_d = acc_s_q + AW'(prod_s);
                acc_c_d = acc_c_q + AW'(prod_c);
            end
            if (idx_q == LAST) begin
                idx_d  = '0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Output stage: scale the completed sums and saturate to OW bits.
    logic signed [AW-1:0] sh_s, sh_c;
    logic signed [OW-1:0] out_i_d, out_q_d, out_i_q, out_q_q;
    logic                 sat_d, sat_q;

    assign sh_s    = acc_s_d >>> SHIFT;
    assign sh_c    = acc_c_d >>> SHIFT;
    assign out_i_d = sat_ow(sh_s);
    assign out_q_d = sat_ow(sh_c);
    assign sat_d   = is_sat(sh_s) || is_sat(sh_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            acc_s_q <= '0;
            acc_c_q <= '0;
            vld_q   <= 1'b0;
            out_i_q <= '0;
            out_q_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_s_q <= acc_s_d;
            acc_c_q <= acc_c_d;
            vld_q   <= done_d;
            if (done_d) begin
                out_i_q <= out_i_d;
                out_q_q <= out_q_d;
                sat_q   <= sat_d;
            end
        end
    end

`ifdef CORR_IQ_MAG_EN
    function automatic logic [OW:0] mag_fn(input logic signed [OW-1:0] a,
                                           input logic signed [OW-1:0] b);
        logic signed [OW:0] ae, be;
        ae = (OW+1)'(a);
        be = (OW+1)'(b);
        if (ae[OW]) ae = -ae;
        if (be[OW]) be = -be;
        return ae + be;
    endfunction

    logic [OW:0] mag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
        end else if (done_d) begin
            mag_q <= mag_fn(out_i_d, out_q_d);
        end
    end

    assign out_mag = mag_q;
`else
    assign out_mag = '0;
`endif

    assign out_valid = vld_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_sat   = sat_q;
    assign idx       = idx_q;

endmodule

// File: tb/tb_corr_iq.sv
// Randomized bench for corr_iq: default build plus a SHIFT=0 instance on shared stimulus,
// both compared every cycle against a window-sum reference model.
module tb_corr_iq;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int N  = 20;
    localparam int OW = 10;
    localparam int SH = DW + CW + $clog2(N) - OW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;

    logic                 a_v, b_v, a_s, b_s;
    logic signed [OW-1:0] a_i, a_q, b_i, b_q;
    logic        [OW:0]   a_m, b_m;
    logic        [4:0]    a_idx, b_idx;

    corr_iq dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(a_v), .out_i(a_i), .out_q(a_q), .out_sat(a_s), .out_mag(a_m), .idx(a_idx)
    );

    corr_iq #(.SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_v), .out_i(b_i), .out_q(b_q), .out_sat(b_s), .out_mag(b_m), .idx(b_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: samples of the open window, plus last expected result per instance.
    int sin_t [N];
    int cos_t [N];
    int win [$];
    bit ev;
    int ei [2];
    int eq [2];
    int em [2];
    bit es [2];
    int pulses;
    int last_i, last_q;

    function automatic int clip(input longint v, inout bit s);
        if (v > 2**(OW-1) - 1) begin s = 1'b1; return 2**(OW-1) - 1; end
        if (v < -(2**(OW-1)))  begin s = 1'b1; return -(2**(OW-1)); end
        return int'(v);
    endfunction

    function automatic void make_exp(input int s, input int sh);
        longint ai, aq;
        bit     sat;
        ai = 0;
        aq = 0;
        for (int k = 0; k < N; k++) begin
            ai += longint'(win[k]) * sin_t[k];
            aq += longint'(win[k]) * cos_t[k];
        end
        sat   = 1'b0;
        ei[s] = clip(ai >>> sh, sat);
        eq[s] = clip(aq >>> sh, sat);
        es[s] = sat;
`ifdef CORR_IQ_MAG_EN
        em[s] = (ei[s] < 0 ? -ei[s] : ei[s]) + (eq[s] < 0 ? -eq[s] : eq[s]);
`else
        em[s] = 0;
`endif
    endfunction

    task automatic compare_all();
        check("valid",  a_v,   ev);
        check("valid0", b_v,   ev);
        check("idx",    a_idx, win.size());
        check("idx0",   b_idx, win.size());
        check("out_i",  a_i,   ei[0]);
        check("out_q",  a_q,   eq[0]);
        check("sat",    a_s,   es[0]);
        check("mag",    a_m,   em[0]);
        check("out_i0", b_i,   ei[1]);
        check("out_q0", b_q,   eq[1]);
        check("sat0",   b_s,   es[1]);
        check("mag0",   b_m,   em[1]);
        if (a_v) begin
            pulses++;
            last_i = a_i;
            last_q = a_q;
        end
    endtask

    task automatic cyc(input bit v, input int d, input bit c);
        in_valid = v;
        in_data  = DW'(d);
        clr      = c;
        @(posedge clk);
        ev = 1'b0;
        if (c) begin
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() == N) begin
                make_exp(0, SH);
                make_exp(1, 0);
                ev = 1'b1;
                win.delete();
            end
        end
        #1;
        compare_all();
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic feed(input int d, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 3)) cyc(1'b0, rnd(), 1'b0);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        win.delete();
        ev = 1'b0;
        for (int s = 0; s < 2; s++) begin
            ei[s] = 0; eq[s] = 0; em[s] = 0; es[s] = 1'b0;
        end
        #1 compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            real rs, rc;
            rs = 127.0 * $sin(2.0 * 3.14159265358979323846 * k / N);
            rc = 127.0 * $cos(2.0 * 3.14159265358979323846 * k / N);
            sin_t[k] = $rtoi(rs + (rs >= 0.0 ? 0.5 : -0.5));
            cos_t[k] = $rtoi(rc + (rc >= 0.0 ? 0.5 : -0.5));
        end
        ev = 1'b0;
        for (int s = 0; s < 2; s++) begin
            ei[s] = 0; eq[s] = 0; em[s] = 0; es[s] = 1'b0;
        end
        pulses = 0;

        #1 rst = 1'b1;
        #1 compare_all();
        #5 rst = 1'b0;

        // all-zero window
        pulses = 0;
        for (int k = 0; k < N; k++) feed(0, 1'b0);
        check("p_zero", pulses, 1);

        // sine input: I carries the energy
        pulses = 0;
        for (int k = 0; k < N; k++) feed(sin_t[k], 1'b0);
        check("p_sin", pulses, 1);
        check("i_sin_rng", (last_i >= 77 && last_i <= 79), 1);
        check("q_sin_rng", (last_q >= -1 && last_q <= 1), 1);

        // full-scale square-ish input saturates the unshifted instance
        for (int k = 0; k < N; k++) feed(sin_t[k] > 0 ? 127 : -128, 1'b0);
        check("i_sat0", b_i, 511);
        check("s_sat0", b_s, 1);

        // two cosine windows with random gaps
        pulses = 0;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < N; k++) feed(cos_t[k], 1'b1);
            check("q_cos_rng", (last_q >= 77 && last_q <= 79), 1);
            check("i_cos_rng", (last_i >= -1 && last_i <= 1), 1);
        end
        check("p_cos", pulses, 2);

        // abort at idx 10, then a clean sine window
        pulses = 0;
        for (int k = 0; k < 10; k++) feed(rnd(), 1'b1);
        cyc(1'b1, rnd(), 1'b1);
        for (int k = 0; k < N; k++) feed(sin_t[k], 1'b0);
        check("p_clr10", pulses, 1);
        check("i_clr10_rng", (last_i >= 77 && last_i <= 79), 1);

        // clr with a valid sample at idx N-1 yields no result
        pulses = 0;
        for (int k = 0; k < N - 1; k++) feed(rnd(), 1'b0);
        cyc(1'b1, rnd(), 1'b1);
        cyc(1'b0, 0, 1'b0);
        check("p_clr_last", pulses, 0);

        // back-to-back random windows
        pulses = 0;
        for (int k = 0; k < 3 * N; k++) feed(rnd(), 1'b0);
        check("p_b2b", pulses, 3);

        // random valid/clr mix
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom_range(0, 39));
            cyc(r < 25, rnd(), r == 0);
        end

        // reset at idx 7, then a fresh sine window
        cyc(1'b0, 0, 1'b1);
        for (int k = 0; k < 7; k++) feed(rnd(), 1'b0);
        mid_reset();
        pulses = 0;
        for (int k = 0; k < N; k++) feed(sin_t[k], 1'b0);
        check("p_rst", pulses, 1);
        check("i_rst_rng", (last_i >= 77 && last_i <= 79), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/corr_iq.md
CORR_IQ -- requirements
Module: corr_iq

Interface
REQ-001 Parameter DW, 8, signed input sample width.
REQ-002 Parameter CW, 8, signed coefficient width; coefficient magnitude 2^(CW-1)-1.
REQ-003 Parameter N, 20, samples per correlation window; legal range 4..256.
REQ-004 Parameter OW, 10, signed output width per channel.
REQ-005 Parameter SHIFT, AW-OW, right shift applied to accumulators before output; AW = DW+CW+clog2(N).
REQ-006 clk  input  1  clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 clr  input  1  synchronous window abort/restart.
REQ-009 in_valid  input  1  in_data valid this cycle.
REQ-010 in_data  input  DW  signed sample.
REQ-011 out_valid  output  1  one-cycle pulse, new result on out_i/out_q.
REQ-012 out_i  output  OW  signed in-phase (sine) correlation result.
REQ-013 out_q  output  OW  signed quadrature (cosine) correlation result.
REQ-014 out_sat  output  1  either channel saturated in the result qualified by out_valid.
REQ-015 out_mag  output  OW+1  unsigned magnitude estimate (see Configuration).
REQ-016 idx  output  clog2(N)  current sample index within window.

Function
REQ-017 Coefficients SHALL be elaboration-time constants: sin_k = round(M*sin(2*pi*k/N)), cos_k = round(M*cos(2*pi*k/N)), M = 2^(CW-1)-1, k = 0..N-1.
REQ-018 A sample SHALL be accepted only on a cycle with in_valid=1 and clr=0; cycles with in_valid=0 leave idx and accumulators unchanged (gaps allowed).
REQ-019 On acceptance at idx=0 the accumulators SHALL load in_data*sin_0 and in_data*cos_0 (no carry-over from prior window); at idx>0 they add in_data*sin_idx / in_data*cos_idx.
REQ-020 Accumulators SHALL be signed AW bits; no internal overflow possible for legal parameters.
REQ-021 idx SHALL increment per accepted sample and wrap N-1 -> 0.
REQ-022 Acceptance at idx=N-1 SHALL cause out_valid=1 on the next cycle, with out_i/out_q = final accumulator (including the N-1 product) arithmetic-shifted right by SHIFT, truncated toward -inf.
REQ-023 Shifted values outside the OW signed range SHALL saturate to +2^(OW-1)-1 or -2^(OW-1); out_sat=1 with that result if either channel saturated, else 0.
REQ-024 out_i, out_q, out_sat, out_mag SHALL hold until the next out_valid; out_valid SHALL be high for exactly one cycle per completed window.
REQ-025 A sample accepted at idx=0 in the same cycle out_valid is high SHALL start the next window normally (back-to-back windows, zero dead cycles).
REQ-026 clr=1 SHALL set idx=0 and clear accumulators next cycle; in_valid ignored that cycle; a pending result already registered is not cancelled; clr at idx=N-1 with in_valid=1 produces no out_valid.

Reset
REQ-027 rst=1 SHALL asynchronously force idx=0, accumulators=0, out_valid=0, out_i=0, out_q=0, out_sat=0, out_mag=0.
REQ-028 Reset mid-window SHALL discard the partial window; first accepted sample after release is idx=0.

Configuration
REQ-029 Macro CORR_IQ_MAG_EN defined: out_mag = |out_i|+|out_q| computed from the saturated values, registered and updated in the same cycle as out_i/out_q.
REQ-030 CORR_IQ_MAG_EN undefined: magnitude logic absent; out_mag tied to 0; all other behaviour identical.

Verification
REQ-031 Defaults, 20 samples of in_data=0 -> single out_valid, out_i=0, out_q=0, out_sat=0.
REQ-032 Defaults, in_data_k = sin_k (round(127*sin(2*pi*k/20))) -> out_i within 78+/-1, out_q within 0+/-1, out_sat=0; with MAG_EN out_mag = |out_i|+|out_q|.
REQ-033 SHIFT=0 override, 20 samples of in_data=127 at k where sin_k>0 else -128 -> out_i=511, out_sat=1.
REQ-034 Defaults, 40 consecutive samples in_data=cos_k with random in_valid gaps -> exactly two out_valid pulses, each out_q within 78+/-1, out_i within 0+/-1; results identical to gap-free run.
REQ-035 clr at idx=10, then 20 samples of sin_k -> exactly one out_valid, out_i within 78+/-1; rst asserted at idx=7 -> all outputs 0 immediately, idx=0.
